// File: rtl/ucsbece154a_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154a_mc_controller
// Brief    : Moore control FSM for the multicycle RV32I core. Steps the
//            shared memory, PC, IR, ALU and register file through
//            fetch/decode/execute/memory/writeback and drives every
//            datapath enable and mux select.
// Revision : 1.0 - initial release
// ============================================================================
module ucsbece154a_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  output logic       PCWrite_o,
  output logic       AdrSrc_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic [1:0] ResultSrc_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALUControl_o,
  output logic [2:0] ImmSrc_o,
  output logic       illegal_o,
  output logic       instret_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_t;

  // Per-state Moore control word, registered alongside the state
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       instret;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    aluop_t     alu_op;
  } ctrl_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;
  logic   known_op;
  logic   skip_illegal;
  logic   branch_taken;

  // Control word that each state presents to the datapath
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      MEMREAD: begin
        c.adr_src = 1'b1;
      end
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.instret    = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
        c.instret   = 1'b1;
      end
      EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = ALU_FUNCT;
      end
      EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        c.reg_write = 1'b1;
        c.instret   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = ALU_SUB;
        c.branch    = 1'b1;
        c.instret   = 1'b1;
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      LUI: begin
        c.result_src = 2'b11;
        c.reg_write  = 1'b1;
        c.instret    = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // Recognise the opcodes this controller can sequence
  always_comb begin
    known_op = 1'b0;
    case (op_i)
      OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BR, OP_JAL, OP_LUI: known_op = 1'b1;
      default: known_op = 1'b0;
    endcase
  end

  // Next-state selection; unsupported opcodes fall straight back to FETCH
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (op_i)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECR;
          OP_ITYPE:     next_state = EXECI;
          OP_BR:        next_state = BRANCH;
          OP_JAL:       next_state = JAL;
          OP_LUI:       next_state = LUI;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (op_i == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: next_state = MEMWB;
      EXECR:   next_state = ALUWB;
      EXECI:   next_state = ALUWB;
      JAL:     next_state = ALUWB;
      default: next_state = FETCH;
    endcase
  end

  // State register plus the registered control word for the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= ctrl_for(FETCH);
    end else begin
      state <= next_state;
      ctrl  <= ctrl_for(next_state);
    end
  end

  // Only beq/bne resolve; other branch funct3 values never redirect the PC
  assign branch_taken = (funct3_i[2:1] == 2'b00) & (zero_i ^ funct3_i[0]);
  assign skip_illegal = (state == DECODE) & ~known_op;

  // Write enables and pulses are held low for as long as reset is asserted
  assign PCWrite_o   = ~reset & (ctrl.pc_update | (ctrl.branch & branch_taken));
  assign MemWrite_o  = ~reset & ctrl.mem_write;
  assign IRWrite_o   = ~reset & ctrl.ir_write;
  assign RegWrite_o  = ~reset & ctrl.reg_write;
  assign illegal_o   = ~reset & skip_illegal;
  assign instret_o   = ~reset & (ctrl.instret | skip_illegal);
  assign AdrSrc_o    = ctrl.adr_src;
  assign ResultSrc_o = ctrl.result_src;
  assign ALUSrcA_o   = ctrl.alu_src_a;
  assign ALUSrcB_o   = ctrl.alu_src_b;
  assign state_o     = state;

  // ALU operation select from the abstract ALUOp and the instruction fields
  always_comb begin
    ALUControl_o = 3'b000;
    case (ctrl.alu_op)
      ALU_ADD: ALUControl_o = 3'b000;
      ALU_SUB: ALUControl_o = 3'b001;
      ALU_FUNCT: begin
        case (funct3_i)
          3'b000:  ALUControl_o = (op_i[5] & funct7b5_i) ? 3'b001 : 3'b000;
          3'b001:  ALUControl_o = 3'b110;
          3'b010:  ALUControl_o = 3'b101;
          3'b100:  ALUControl_o = 3'b100;
          3'b101:  ALUControl_o = 3'b111;
          3'b110:  ALUControl_o = 3'b011;
          3'b111:  ALUControl_o = 3'b010;
          default: ALUControl_o = 3'b000;
        endcase
      end
      default: ALUControl_o = 3'b000;
    endcase
  end

  // Immediate format select straight from the opcode, valid in every state
  always_comb begin
    ImmSrc_o = 3'b000;
    case (op_i)
      OP_SW:   ImmSrc_o = 3'b001;
      OP_BR:   ImmSrc_o = 3'b010;
      OP_JAL:  ImmSrc_o = 3'b011;
      OP_LUI:  ImmSrc_o = 3'b100;
      default: ImmSrc_o = 3'b000;
    endcase
  end

endmodule
`default_nettype wire
